// File: rtl/mdm_pkg.sv
// mdm_pkg: shared command opcodes, offset-select codes and calibrator state type.
package mdm_pkg;
  localparam logic [7:0] CMD_OFFSET_VALUE = 8'h03;
  localparam logic [7:0] CMD_CAL_OFFSET = 8'h04;
  localparam logic [7:0] CMD_OFFSET_MUX = 8'h05;
  localparam logic [7:0] OFFSET_MUX_BYPASS = 8'h00;
  localparam logic [7:0] OFFSET_MUX_MANUAL = 8'h01;
  localparam logic [7:0] OFFSET_MUX_CAL = 8'h02;
  typedef enum logic {CAL_IDLE, CAL_RUN} cal_state_t;
endpackage

// File: rtl/adc_offset_cutter_calibrator.sv
// offset_calibrator: averages 2^CAL_LOG2 accepted samples into a rounded offset.
module offset_calibrator
  import mdm_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int CAL_LOG2 = 8
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  input  logic             accept,
  input  logic             cal_start,
  output logic [WIDTH-1:0] cal_value,
  output logic             cal_busy,
  output logic             cal_done
);
  localparam int AW = WIDTH + CAL_LOG2;
  localparam int CW = CAL_LOG2 + 1;
  localparam logic [AW-1:0] HALF = AW'(1) << (CAL_LOG2 - 1);
  localparam logic [CW-1:0] LAST = CW'((1 << CAL_LOG2) - 1);
  cal_state_t state, state_nxt;
  logic [AW-1:0] acc, acc_nxt, sum, rnd;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] val_nxt;
  logic done_nxt;
  assign cal_busy = state == CAL_RUN;
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state <= CAL_IDLE;
      acc <= '0;
      cnt <= '0;
      cal_value <= '0;
      cal_done <= 1'b0;
    end else begin
      state <= state_nxt;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      cal_value <= val_nxt;
      cal_done <= done_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    acc_nxt = acc;
    cnt_nxt = cnt;
    val_nxt = cal_value;
    done_nxt = 1'b0;
    sum = acc + AW'(sample);
    rnd = sum + HALF;
    if (clear) begin
      state_nxt = CAL_IDLE;
      acc_nxt = '0;
      cnt_nxt = '0;
    end else if (state == CAL_IDLE && cal_start) begin
      state_nxt = CAL_RUN;
      acc_nxt = '0;
      cnt_nxt = '0;
    end else if (state == CAL_RUN && accept) begin
      acc_nxt = sum;
      cnt_nxt = cnt + 1'b1;
      if (cnt == LAST) begin
        val_nxt = WIDTH'(rnd >> CAL_LOG2);
        done_nxt = 1'b1;
        state_nxt = CAL_IDLE;
      end
    end
  end
endmodule

// File: rtl/adc_offset_cutter.sv
// adc_offset_cutter: subtracts a selectable DC offset from the ADC stream, 1-cycle latency.
module adc_offset_cutter
  import mdm_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int CAL_LOG2 = 8
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             clear,
  input  logic [15:0]      offset_value,
  input  logic [7:0]       offset_mux,
  input  logic             cal_start,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH:0]   o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             cal_busy,
  output logic             cal_done,
  output logic [WIDTH-1:0] cal_value
);
  logic accept;
  logic [WIDTH-1:0] eff;
  assign i_tready = ~o_tvalid | o_tready;
  assign accept = i_tvalid & i_tready;
  always_comb eff = offset_mux == OFFSET_MUX_MANUAL ? WIDTH'(offset_value) :
                    offset_mux == OFFSET_MUX_CAL ? cal_value : '0;
  always_ff @(posedge CLOCK) begin
    if (rst || clear) begin
      o_tvalid <= 1'b0;
      o_tdata <= '0;
    end else if (accept) begin
      o_tvalid <= 1'b1;
      o_tdata <= {1'b0, i_tdata} - {1'b0, eff};
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end
  offset_calibrator #(.WIDTH(WIDTH), .CAL_LOG2(CAL_LOG2)) u_cal (
    .CLOCK(CLOCK),
    .rst(rst),
    .clear(clear),
    .sample(i_tdata),
    .accept(accept),
    .cal_start(cal_start),
    .cal_value(cal_value),
    .cal_busy(cal_busy),
    .cal_done(cal_done)
  );
endmodule

// File: doc/adc_offset_cutter.md
Name: adc_offset_cutter

Overview:
- Streaming DC-offset removal stage between the LTC2312 ADC output stream and the BoundedIntegrator filter input.
- Converts each unsigned WIDTH-bit ADC sample into a signed WIDTH+1-bit sample by subtracting an offset. The offset is selected per sample as none, the host-written value, or a value measured by an on-block calibration averager.
- Driven by the existing command registers: offset_value (cmd 0x03), cal_offset pulse (cmd 0x04), offset_mux (cmd 0x05).

Parameters:
- WIDTH, 14, ADC sample width in bits (unsigned input).
- CAL_LOG2, 8, log2 of the number of samples averaged per calibration; legal range 1..12.

Ports:
- CLOCK  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear: aborts calibration and flushes the output register.
- offset_value  input  16  manual offset; bits [WIDTH-1:0] are used and upper bits are ignored.
- offset_mux  input  8  offset select: 0x00 bypass, 0x01 manual, 0x02 calibrated, any other code bypass.
- cal_start  input  1  single-cycle calibration request.
- i_tdata  input  WIDTH  unsigned ADC sample.
- i_tvalid  input  1  input valid.
- i_tready  output  1  input ready.
- o_tdata  output  WIDTH+1  signed two's-complement result.
- o_tvalid  output  1  output valid.
- o_tready  input  1  downstream ready.
- cal_busy  output  1  high while calibration is accumulating.
- cal_done  output  1  single-cycle pulse when cal_value updates.
- cal_value  output  WIDTH  last calibrated offset.

Behaviour:
- Reset values (rst high at a CLOCK edge): o_tvalid=0, o_tdata=0, cal_busy=0, cal_done=0, cal_value=0, accumulator=0, sample counter=0, FSM=IDLE.

Handshake:
- AXI-Stream. i_tready = ~o_tvalid | o_tready, purely combinational from o_tvalid and o_tready.
- A sample is accepted when i_tvalid & i_tready.
- Latency is 1 cycle: an accepted sample appears on o_tdata with o_tvalid=1 at the next edge.
- o_tvalid clears on o_tvalid & o_tready when no new sample is accepted.
- o_tdata holds stable while o_tvalid & ~o_tready.
- Full throughput of one sample per cycle is sustained while o_tready=1.

Arithmetic:
- Effective offset eff = 0 (bypass), offset_value[WIDTH-1:0] (manual), or cal_value (calibrated).
- eff is sampled combinationally in the acceptance cycle.
- o_tdata = {1'b0,i_tdata} - {1'b0,eff}, computed WIDTH+1 bits wide.
- Result range is -(2^WIDTH-1)..+(2^WIDTH-1), so no overflow and no saturation logic are needed.

Calibration FSM:
- IDLE: cal_start=1 moves to CAL next edge and zeroes the accumulator and counter. A sample accepted in the same cycle as cal_start is not counted.
- CAL: cal_busy=1.
  - Each accepted sample adds i_tdata to the accumulator (width WIDTH+CAL_LOG2) and increments the counter (width CAL_LOG2+1).
  - At the edge accepting sample number 2^CAL_LOG2: cal_value <= (acc_total + 2^(CAL_LOG2-1)) >> CAL_LOG2, where acc_total includes that last sample; also cal_done <= 1 and FSM <= IDLE.
  - The rounded result never exceeds 2^WIDTH-1.
- cal_start during CAL is ignored; the calibration in progress is not restarted.
- Data path keeps streaming during CAL using the current eff. A calibrated-mode sample accepted in the same cycle that cal_value updates uses the old cal_value.
- Stalled input (i_tvalid=0 or backpressure) pauses accumulation; there is no timeout.
- clear:
  - Next edge sets o_tvalid=0 and FSM=IDLE, and zeroes the accumulator and counter.
  - cal_value is retained and cal_done is not pulsed.
  - Any input accepted in the clear cycle is dropped.
- rst or clear mid-calibration aborts it; a new cal_start is required.
- offset_mux changes take effect on the next accepted sample; there is no pipeline flush.

Decomposition:
- Shared package mdm_pkg: OFFSET_MUX_BYPASS=8'h00, OFFSET_MUX_MANUAL=8'h01, OFFSET_MUX_CAL=8'h02. The command opcodes 0x03/0x04/0x05 are shared with the command decoder.
- One sub-module, offset_calibrator: owns the IDLE/CAL FSM, accumulator, counter and cal_value. Inputs: sample, accept strobe, cal_start, clear. Outputs: cal_value, cal_busy, cal_done.
- adc_offset_cutter keeps the mux, subtractor and output register.

Test Plan:
1. Bypass, WIDTH=14: send 0x0000, 0x1FFF, 0x3FFF with o_tready=1. Expect o_tdata 0, +8191, +16383, each one cycle after acceptance, back-to-back.
2. Manual: offset_value=0x2000, mux=0x01; send 0x0000, 0x2000, 0x3FFF. Expect o_tdata = -8192 (15'h6000), 0, +8191.
3. Calibration, CAL_LOG2=4: pulse cal_start, then feed 16 samples alternating 100/101. Expect cal_busy high during the 16 accepts, cal_done one cycle after the 16th accept, and cal_value=101 (1608+8 >>4 = 101). Then mux=0x02, send 101: o_tdata=0.
4. Backpressure: hold o_tready=0 with o_tvalid=1. Expect i_tready=0 and o_tdata stable for 10 cycles. Release: the held word transfers and the next sample is accepted in the same cycle.
5. Abort: assert clear after 7 calibration samples. Expect cal_busy=0, cal_value unchanged, no cal_done. A second cal_start during CAL is ignored (done still occurs at 16 samples).
6. Reset mid-stream: assert rst with o_tvalid=1 during CAL. Expect all outputs 0 next cycle, cal_value=0, FSM IDLE.
